// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: FSM state type and
// default widths used by pc_seq and pc_ret_stack.
package pc_pkg;

    typedef enum logic {
        PC_RUN     = 1'b0,
        PC_HALTED  = 1'b1
    } pc_state_e;

    localparam int PC_W_DEF        = 12;
    localparam int OFF_W_DEF       = 8;
    localparam int STACK_DEPTH_DEF = 4;

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO for pc_seq. DEPTH entries of W bits, power-of-2 depth.
// Push while full and pop while empty are ignored here; the caller decides
// what those cases mean. Storage is not reset, only the occupancy count.
module pc_ret_stack
    import pc_pkg::*;
#(
    parameter int DEPTH = STACK_DEPTH_DEF,
    parameter int W     = PC_W_DEF
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] top_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW:0]   cnt_q;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] top_idx;

    // When full, wr_idx wraps to 0 and top_idx wraps to DEPTH-1, which is
    // still the most recent entry.
    assign wr_idx  = cnt_q[AW-1:0];
    assign top_idx = wr_idx - AW'(1);
    assign top_o   = mem_q[top_idx];
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);

    // Occupancy count; clear empties the stack without touching storage
    always_ff @(posedge clk) begin
        if (!reset_n || clear_i) begin
            cnt_q <= '0;
        end else if (push_i && !full_o) begin
            cnt_q <= cnt_q + (AW+1)'(1);
        end else if (pop_i && !empty_o) begin
            cnt_q <= cnt_q - (AW+1)'(1);
        end
    end

    // Entry storage, written on an accepted push
    always_ff @(posedge clk) begin
        if (push_i && !full_o) begin
            mem_q[wr_idx] <= data_i;
        end
    end

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer: RUN/HALTED FSM, stall, absolute/relative branch
// and optional call/return stack driving the instruction-fetch address.
// Optional feature macro: PC_RET_STACK_EN (return stack, call/ret, stk_ovf/stk_unf).
// Without it, call and ret are ignored and both flags read 0.
module pc_seq
    import pc_pkg::*;
#(
    parameter int PC_W        = PC_W_DEF,
    parameter int OFF_W       = OFF_W_DEF,
    parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             halt,
    input  logic             restart,
    input  logic             stall,
    input  logic             branch,
    input  logic             br_rel,
    input  logic [PC_W-1:0]  target,
    input  logic [OFF_W-1:0] offset,
    input  logic             call,
    input  logic             ret,
    output logic [PC_W-1:0]  prog_ct,
    output logic             done,
    output logic             stk_ovf,
    output logic             stk_unf
);

    pc_state_e               state_q;
    logic [PC_W-1:0]         pc_q;
    logic                    done_q;
    logic                    ovf_q;
    logic                    unf_q;

    logic signed [OFF_W-1:0] off_s;
    logic [PC_W-1:0]         pc_inc;
    logic [PC_W-1:0]         pc_rel;
    logic [PC_W-1:0]         pc_br;
    logic                    run_go;
    logic                    call_act;
    logic                    ret_act;
    logic                    stk_full;
    logic                    stk_empty;
    logic [PC_W-1:0]         stk_top;

    // All PC arithmetic wraps modulo 2^PC_W; the offset is sign-extended.
    assign off_s  = offset;
    assign pc_inc = pc_q + PC_W'(1);
    assign pc_rel = pc_q + PC_W'(off_s);
    assign pc_br  = br_rel ? pc_rel : target;

    // A cycle that may act on ret/call/branch: running, not halting, not stalled
    assign run_go = (state_q == PC_RUN) && !halt && !stall;

`ifdef PC_RET_STACK_EN
    logic stk_push;
    logic stk_pop;
    logic stk_clear;

    assign call_act  = call;
    assign ret_act   = ret;
    // ret outranks call, so a push only happens when ret is absent
    assign stk_push  = run_go && !ret && call;
    assign stk_pop   = run_go && ret;
    assign stk_clear = (state_q == PC_HALTED) && restart;

    pc_ret_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (PC_W)
    ) u_stack (
        .clk     (clk),
        .reset_n (reset_n),
        .clear_i (stk_clear),
        .push_i  (stk_push),
        .pop_i   (stk_pop),
        .data_i  (pc_inc),
        .top_o   (stk_top),
        .full_o  (stk_full),
        .empty_o (stk_empty)
    );
`else
    logic unused_cfg;

    // No stack: call/ret fall through the priority chain as if absent
    assign call_act   = 1'b0;
    assign ret_act    = 1'b0;
    assign stk_full   = 1'b0;
    assign stk_empty  = 1'b1;
    assign stk_top    = '0;
    assign unused_cfg = ^{call, ret, (STACK_DEPTH > 1)};
`endif

    // RUN/HALTED FSM with next-PC selection and sticky stack flags
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= PC_RUN;
            pc_q    <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            case (state_q)
                PC_RUN: begin
                    if (halt) begin
                        state_q <= PC_HALTED;
                        done_q  <= 1'b1;
                    end else if (stall) begin
                        pc_q <= pc_q;
                    end else if (ret_act) begin
                        if (stk_empty) begin
                            pc_q  <= pc_inc;
                            unf_q <= 1'b1;
                        end else begin
                            pc_q <= stk_top;
                        end
                    end else if (call_act) begin
                        pc_q <= target;
                        if (stk_full) begin
                            ovf_q <= 1'b1;
                        end
                    end else if (branch) begin
                        pc_q <= pc_br;
                    end else begin
                        pc_q <= pc_inc;
                    end
                end
                PC_HALTED: begin
                    if (restart) begin
                        state_q <= PC_RUN;
                        done_q  <= 1'b0;
                        pc_q    <= '0;
                    end
                end
                default: begin
                    state_q <= PC_RUN;
                end
            endcase
        end
    end

    assign prog_ct = pc_q;
    assign done    = done_q;
    assign stk_ovf = ovf_q;
    assign stk_unf = unf_q;

endmodule
